if_id_register: RTL and testbench



---
 rtl/pipeline_pkg.sv | 15 +
 rtl/perf_counter.sv | 22 ++
 rtl/if_id_register.sv | 107 ++++++++++
 tb/tb_if_id_register.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the SAD pipeline registers: IF/ID state encoding,
// the NOP word inserted as a bubble, and the PC byte increment.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } ifid_state_t;

  localparam int          DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/perf_counter.sv
// Enable-controlled 32-bit event counter; wraps modulo 2^32, asynchronous
// active-high reset. Only instantiated when IF_ID_PERF_EN is defined.
module perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 32'd0;
    end else if (en) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall (hold) and flush (NOP bubble).
// Optional macro IF_ID_PERF_EN adds instr_count/bubble_count outputs.
module if_id_register
  import pipeline_pkg::*;
#(
  parameter int                DATA_W    = pipeline_pkg::DATA_W_DEF,
  parameter logic [DATA_W-1:0] PC_INC    = DATA_W'(pipeline_pkg::PC_INC),
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(pipeline_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pc_plus4_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              valid_out,
  output logic              hold_out
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       bubble_count
`endif
);

  ifid_state_t       state_reg, state_next;
  logic [DATA_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] pc_plus4_reg, pc_plus4_next;
  logic [DATA_W-1:0] instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic              capture_en;
  logic              bubble_en;

  // Priority flush > stall > capture; default is to hold everything.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pc_plus4_next = pc_plus4_reg;
    instr_next    = instr_reg;
    valid_next    = valid_reg;
    capture_en    = 1'b0;
    bubble_en     = 1'b0;

    if (flush) begin
      // The squashed slot keeps its PC for debug but is never valid.
      pc_next       = pc_in;
      pc_plus4_next = pc_in + PC_INC;
      instr_next    = NOP_INSTR;
      valid_next    = 1'b0;
      state_next    = BUBBLE;
      bubble_en     = 1'b1;
    end else if (stall) begin
      state_next = HOLD;
    end else begin
      pc_next       = pc_in;
      pc_plus4_next = pc_in + PC_INC;
      instr_next    = instr_in;
      valid_next    = 1'b1;
      state_next    = RUN;
      capture_en    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= BUBBLE;
      pc_reg       <= '0;
      pc_plus4_reg <= '0;
      instr_reg    <= NOP_INSTR;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pc_plus4_reg <= pc_plus4_next;
      instr_reg    <= instr_next;
      valid_reg    <= valid_next;
    end
  end

  assign pc_out       = pc_reg;
  assign pc_plus4_out = pc_plus4_reg;
  assign instr_out    = instr_reg;
  assign valid_out    = valid_reg;
  assign hold_out     = (state_reg == HOLD);

`ifdef IF_ID_PERF_EN
  perf_counter u_instr_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (capture_en),
    .count (instr_count)
  );

  perf_counter u_bubble_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (bubble_en),
    .count (bubble_count)
  );
`else
  logic unused_perf;
  assign unused_perf = capture_en ^ bubble_en;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Randomized self-checking bench for if_id_register against a behavioural
// model of the IF/ID slot (capture / hold / squash rules).
module tb_if_id_register;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instr_in;
  logic        stall, flush;
  logic [31:0] pc_out, pc_plus4_out, instr_out;
  logic        valid_out, hold_out;
`ifdef IF_ID_PERF_EN
  logic [31:0] instr_count, bubble_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_no     = 0;

  // Reference model state
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_hold;
  logic [31:0] m_icnt, m_bcnt;

  if_id_register dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .instr_in     (instr_in),
    .stall        (stall),
    .flush        (flush),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .hold_out     (hold_out)
`ifdef IF_ID_PERF_EN
    ,
    .instr_count  (instr_count),
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    tests_run++;
    if (obs !== exp_val) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle_no, obs, exp_val);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_hold = 1'b0;
    m_icnt = 32'h0; m_bcnt = 32'h0;
  endtask

  // One edge of the slot: a flushed slot is a bubble, a stalled slot is
  // untouched, otherwise the fetched word and its PC move into decode.
  task automatic model_edge();
    if (flush) begin
      m_pc = pc_in; m_pc4 = pc_in + 32'd4; m_instr = 32'h0;
      m_valid = 1'b0; m_hold = 1'b0; m_bcnt = m_bcnt + 1;
    end else if (stall) begin
      m_hold = 1'b1;
    end else begin
      m_pc = pc_in; m_pc4 = pc_in + 32'd4; m_instr = instr_in;
      m_valid = 1'b1; m_hold = 1'b0; m_icnt = m_icnt + 1;
    end
  endtask

  task automatic compare_all();
    check("pc_out",       pc_out,                m_pc);
    check("pc_plus4_out", pc_plus4_out,          m_pc4);
    check("instr_out",    instr_out,             m_instr);
    check("valid_out",    {31'b0, valid_out},    {31'b0, m_valid});
    check("hold_out",     {31'b0, hold_out},     {31'b0, m_hold});
`ifdef IF_ID_PERF_EN
    check("instr_count",  instr_count,  m_icnt);
    check("bubble_count", bubble_count, m_bcnt);
`endif
  endtask

  // Called just after an active edge; drives inputs, waits one edge, checks.
  task automatic step(input logic [31:0] p, input logic [31:0] i, input logic s, input logic f);
    pc_in = p; instr_in = i; stall = s; flush = f;
    @(posedge clk);
    cycle_no++;
    model_edge();
    #1;
    $display("[TB] cyc=%0d pc_in=%h instr_in=%h stall=%b flush=%b -> pc=%h pc4=%h instr=%h v=%b h=%b",
             cycle_no, p, i, s, f, pc_out, pc_plus4_out, instr_out, valid_out, hold_out);
    compare_all();
  endtask

  // Reset pulse inside a cycle, well clear of any edge; outputs must clear at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    $display("[TB] async reset at t=%0t", $time);
    compare_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rp, ri;
    logic        rs, rf;

    rst = 1'b1; pc_in = 32'h0; instr_in = 32'h0; stall = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_edge();  // inputs are capture-mode zeros during this edge
    compare_all();

    // Normal capture
    step(32'h0000_0010, 32'h8C08_0000, 1'b0, 1'b0);
    check("capture_pc4", pc_plus4_out, 32'h0000_0014);
    // Three-cycle stall with changing inputs, then release
    step(32'h0000_0014, 32'h1111_1111, 1'b1, 1'b0);
    step(32'h0000_0018, 32'h2222_2222, 1'b1, 1'b0);
    step(32'h0000_001C, 32'h3333_3333, 1'b1, 1'b0);
    check("stall_frozen_instr", instr_out, 32'h8C08_0000);
    step(32'h0000_0020, 32'h4444_4444, 1'b0, 1'b0);
    // Flush together with stall, then stall on the bubble
    step(32'h0000_0020, 32'h5555_5555, 1'b1, 1'b1);
    check("flush_pc", pc_out, 32'h0000_0020);
    step(32'h0000_0024, 32'h6666_6666, 1'b1, 1'b0);
    check("held_bubble_valid", {31'b0, valid_out}, 32'h0);
    // PC wrap
    step(32'hFFFF_FFFC, 32'h7777_7777, 1'b0, 1'b0);
    check("wrap_pc4", pc_plus4_out, 32'h0000_0000);
    // Reset while stalled
    step(32'h0000_0100, 32'h8888_8888, 1'b1, 1'b0);
    async_reset();

`ifdef IF_ID_PERF_EN
    // 5 captures, 2 flushes, 3 stalls from a clean reset
    async_reset();
    for (int k = 0; k < 5; k++) step(32'h40 + 32'(k) * 4, 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) step(32'h80, 32'hB000_0000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(32'h84, 32'hC000_0000, 1'b1, 1'b0);
    check("perf_instr_count", instr_count, 32'd5);
    check("perf_bubble_count", bubble_count, 32'd2);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00})
                                       : {$urandom, 2'b00};
      ri = $urandom;
      rs = ($urandom_range(0, 99) < 30);
      rf = ($urandom_range(0, 99) < 15);
      step(rp, ri, rs, rf);
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout cycle=%0d got=running expected=finished", cycle_no);
    $fatal(1, "timeout");
  end

endmodule
